// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus port between the fetch (I) and data (D) requesters.
// One outstanding transaction; D has priority, a starvation counter keeps fetch moving.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             resetn,

    input  logic             i_valid,
    input  logic [31:0]      i_addr,
    output logic             i_addr_ok,
    output logic             i_data_ok,
    output logic [31:0]      i_data,

    input  logic             d_valid,
    input  logic [31:0]      d_addr,
    input  logic             d_write,
    input  logic [3:0]       d_strobe,
    input  logic [31:0]      d_wdata,
    output logic             d_addr_ok,
    output logic             d_data_ok,
    output logic [31:0]      d_rdata,

    output logic             m_valid,
    output logic [31:0]      m_addr,
    output logic             m_write,
    output logic [3:0]       m_strobe,
    output logic [31:0]      m_wdata,
    input  logic             m_addr_ok,
    input  logic             m_data_ok,
    input  logic [31:0]      m_rdata,

    output logic             busy,
    output logic [1:0]       dbg_state,
    output logic [CNT_W-1:0] dbg_starve_cnt
);

    // Handshake: a requester holds *_valid and its fields until it sees *_addr_ok;
    // the memory accepts on m_valid & m_addr_ok and answers later with a one-cycle
    // m_data_ok, which is forwarded to the granted requester as *_data_ok.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic             gnt_d;
    logic [CNT_W-1:0] starve_cnt;
    logic [31:0]      lat_addr;
    logic             lat_write;
    logic [3:0]       lat_strobe;
    logic [31:0]      lat_wdata;

    logic pick_d;
    logic pick_i;

    // D wins unless I has been passed over STARVE_LIMIT times in a row.
    always_comb begin
        pick_d = 1'b0;
        pick_i = 1'b0;
        if (d_valid && (starve_cnt != LIMIT || !i_valid)) begin
            pick_d = 1'b1;
        end else if (i_valid) begin
            pick_i = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            gnt_d      <= 1'b0;
            starve_cnt <= '0;
            lat_addr   <= '0;
            lat_write  <= 1'b0;
            lat_strobe <= '0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state      <= ISSUE;
                        gnt_d      <= 1'b1;
                        lat_addr   <= d_addr;
                        lat_write  <= d_write;
                        lat_strobe <= d_strobe;
                        lat_wdata  <= d_wdata;
                        if (i_valid && starve_cnt != LIMIT) begin
                            starve_cnt <= starve_cnt + CNT_ONE;
                        end
                    end else if (pick_i) begin
                        state      <= ISSUE;
                        gnt_d      <= 1'b0;
                        lat_addr   <= i_addr;
                        lat_write  <= 1'b0;
                        lat_strobe <= '0;
                        lat_wdata  <= '0;
                        starve_cnt <= '0;
                    end
                end
                ISSUE: begin
                    if (m_addr_ok) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (m_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic in_issue;
    logic in_wait;

    assign in_issue = (state == ISSUE);
    assign in_wait  = (state == WAIT);

    // Memory side is driven purely from latched copies, never from requester inputs.
    assign m_valid  = in_issue;
    assign m_addr   = lat_addr;
    assign m_write  = lat_write;
    assign m_strobe = lat_strobe;
    assign m_wdata  = lat_wdata;

    assign i_addr_ok = in_issue & ~gnt_d & m_addr_ok;
    assign d_addr_ok = in_issue &  gnt_d & m_addr_ok;
    assign i_data_ok = in_wait  & ~gnt_d & m_data_ok;
    assign d_data_ok = in_wait  &  gnt_d & m_data_ok;
    assign i_data    = i_data_ok ? m_rdata : '0;
    assign d_rdata   = d_data_ok ? m_rdata : '0;

    assign busy           = (state != IDLE);
    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change on the falling edge,
// outputs are checked 1ns after it.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        resetn;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_data;
    logic        d_valid;
    logic [31:0] d_addr;
    logic        d_write;
    logic [3:0]  d_strobe;
    logic [31:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;
    logic        m_valid;
    logic [31:0] m_addr;
    logic        m_write;
    logic [3:0]  m_strobe;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;
    logic        busy;
    logic [1:0]  dbg_state;
    logic [2:0]  dbg_starve_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    mem_bus_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_data(i_data),
        .d_valid(d_valid), .d_addr(d_addr), .d_write(d_write), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_write(m_write), .m_strobe(m_strobe),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .busy(busy), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver: from an IDLE falling edge, run one transaction with 1-cycle memory
    // accept and 1-cycle data return; reports who got addr_ok and the bus address.
    task automatic serve(output logic got_d, output logic got_i, output logic [31:0] addr);
        @(negedge clk);
        m_addr_ok = 1'b1;
        #1;
        got_d = d_addr_ok;
        got_i = i_addr_ok;
        addr  = m_addr;
        @(negedge clk);
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        m_rdata   = 32'h0000_0001;
        @(negedge clk);
        m_data_ok = 1'b0;
        m_rdata   = '0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        i_valid = 0; i_addr = '0;
        d_valid = 0; d_addr = '0; d_write = 0; d_strobe = '0; d_wdata = '0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk_cnt++; if ({m_valid, m_write, m_addr, m_strobe, m_wdata, i_addr_ok, i_data_ok, i_data,
                        d_addr_ok, d_data_ok, d_rdata, busy} !== '0)
            $display("FAIL reset_outputs: got m_valid=%0h m_addr=%0h busy=%0h, expected all 0", m_valid, m_addr, busy);
        else pass_cnt++;
        chk_cnt++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state); else pass_cnt++;
        chk_cnt++; if (dbg_starve_cnt !== 3'd0) $display("FAIL reset_cnt: got %0d expected 0", dbg_starve_cnt); else pass_cnt++;
    endtask

    task automatic test_fetch();
        @(negedge clk);
        i_valid = 1'b1; i_addr = 32'hbfc0_0000;
        #1;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL fetch_t_busy: got %0h expected 0", busy); else pass_cnt++;
        @(negedge clk);
        m_addr_ok = 1'b1;
        #1;
        chk_cnt++; if (m_valid !== 1'b1 || m_addr !== 32'hbfc0_0000 || m_write !== 1'b0)
            $display("FAIL fetch_issue_bus: got v=%0h a=%0h w=%0h expected 1 bfc00000 0", m_valid, m_addr, m_write);
        else pass_cnt++;
        chk_cnt++; if (i_addr_ok !== 1'b1 || d_addr_ok !== 1'b0)
            $display("FAIL fetch_addr_ok: got i=%0h d=%0h expected i=1 d=0", i_addr_ok, d_addr_ok);
        else pass_cnt++;
        i_valid = 1'b0;
        @(negedge clk);
        m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h2402_0001;
        #1;
        chk_cnt++; if (i_data_ok !== 1'b1 || i_data !== 32'h2402_0001)
            $display("FAIL fetch_data: got ok=%0h data=%0h expected 1 24020001", i_data_ok, i_data);
        else pass_cnt++;
        chk_cnt++; if ({m_valid, d_addr_ok, d_data_ok, d_rdata} !== '0 || busy !== 1'b1)
            $display("FAIL fetch_wait_side: got m_valid=%0h d_data_ok=%0h d_rdata=%0h busy=%0h expected 0 0 0 1",
                     m_valid, d_data_ok, d_rdata, busy);
        else pass_cnt++;
        @(negedge clk);
        m_data_ok = 1'b0; m_rdata = '0;
        #1;
        chk_cnt++; if (busy !== 1'b0 || i_data_ok !== 1'b0)
            $display("FAIL fetch_done: got busy=%0h ok=%0h expected 0 0", busy, i_data_ok);
        else pass_cnt++;
        chk_cnt++; if (dbg_starve_cnt !== 3'd0) $display("FAIL fetch_cnt: got %0d expected 0", dbg_starve_cnt); else pass_cnt++;
    endtask

    task automatic test_store();
        d_valid = 1'b1; d_write = 1'b1; d_addr = 32'h8000_1000; d_strobe = 4'b0011; d_wdata = 32'hdead_beef;
        @(negedge clk);
        #1;
        chk_cnt++; if (m_valid !== 1'b1 || m_write !== 1'b1 || m_strobe !== 4'b0011 ||
                       m_wdata !== 32'hdead_beef || m_addr !== 32'h8000_1000)
            $display("FAIL store_bus: got v=%0h w=%0h s=%0h wd=%0h a=%0h expected 1 1 3 deadbeef 80001000",
                     m_valid, m_write, m_strobe, m_wdata, m_addr);
        else pass_cnt++;
        chk_cnt++; if (d_addr_ok !== 1'b0) $display("FAIL store_no_accept: got %0h expected 0", d_addr_ok); else pass_cnt++;
        // requester-side fields change while waiting; the bus must keep the latched copy
        d_write = 1'b0; d_addr = 32'h0; d_strobe = 4'hf; d_wdata = 32'h0;
        @(negedge clk);
        m_addr_ok = 1'b1;
        #1;
        chk_cnt++; if (m_wdata !== 32'hdead_beef || m_strobe !== 4'b0011 || m_write !== 1'b1 || m_addr !== 32'h8000_1000)
            $display("FAIL store_latched: got wd=%0h s=%0h w=%0h a=%0h expected deadbeef 3 1 80001000",
                     m_wdata, m_strobe, m_write, m_addr);
        else pass_cnt++;
        chk_cnt++; if (d_addr_ok !== 1'b1 || i_addr_ok !== 1'b0)
            $display("FAIL store_addr_ok: got d=%0h i=%0h expected 1 0", d_addr_ok, i_addr_ok);
        else pass_cnt++;
        d_valid = 1'b0;
        @(negedge clk);
        m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = '0;
        #1;
        chk_cnt++; if (d_data_ok !== 1'b1 || i_data_ok !== 1'b0)
            $display("FAIL store_data_ok: got d=%0h i=%0h expected 1 0", d_data_ok, i_data_ok);
        else pass_cnt++;
        @(negedge clk);
        m_data_ok = 1'b0;
        #1;
        chk_cnt++; if (d_data_ok !== 1'b0) $display("FAIL store_pulse: got %0h expected 0", d_data_ok); else pass_cnt++;
    endtask

    task automatic test_contention();
        logic        gd, gi;
        logic [31:0] a;
        i_valid = 1'b1; i_addr = 32'h0040_0000;
        d_valid = 1'b1; d_write = 1'b0; d_addr = 32'h8000_2000; d_strobe = '0; d_wdata = '0;
        serve(gd, gi, a);
        d_valid = 1'b0;
        #1;
        chk_cnt++; if (gd !== 1'b1 || gi !== 1'b0 || a !== 32'h8000_2000)
            $display("FAIL contend_first: got d=%0h i=%0h a=%0h expected 1 0 80002000", gd, gi, a);
        else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0 || i_addr_ok !== 1'b0)
            $display("FAIL contend_bubble: got busy=%0h i_addr_ok=%0h expected 0 0", busy, i_addr_ok);
        else pass_cnt++;
        chk_cnt++; if (dbg_starve_cnt !== 3'd1) $display("FAIL contend_cnt1: got %0d expected 1", dbg_starve_cnt); else pass_cnt++;
        serve(gd, gi, a);
        i_valid = 1'b0;
        #1;
        chk_cnt++; if (gd !== 1'b0 || gi !== 1'b1 || a !== 32'h0040_0000)
            $display("FAIL contend_second: got d=%0h i=%0h a=%0h expected 0 1 400000", gd, gi, a);
        else pass_cnt++;
        chk_cnt++; if (dbg_starve_cnt !== 3'd0) $display("FAIL contend_cnt0: got %0d expected 0", dbg_starve_cnt); else pass_cnt++;
    endtask

    task automatic test_starvation();
        logic        gd, gi;
        logic [31:0] a;
        logic        exp_d[10]   = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        logic [2:0]  exp_cnt[10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        i_valid = 1'b1; i_addr = 32'h0040_0100;
        d_valid = 1'b1; d_write = 1'b0; d_addr = 32'h8000_3000;
        for (int k = 0; k < 10; k++) begin
            serve(gd, gi, a);
            if (k == 9) begin
                i_valid = 1'b0; d_valid = 1'b0;
            end
            #1;
            chk_cnt++; if (gd !== exp_d[k] || gi !== ~exp_d[k])
                $display("FAIL starve_grant%0d: got d=%0h i=%0h expected d=%0h", k, gd, gi, exp_d[k]);
            else pass_cnt++;
            chk_cnt++; if (dbg_starve_cnt !== exp_cnt[k])
                $display("FAIL starve_cnt%0d: got %0d expected %0d", k, dbg_starve_cnt, exp_cnt[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        i_valid = 1'b1; i_addr = 32'h0040_0010;
        @(negedge clk);
        i_valid = 1'b0;
        d_valid = 1'b1; d_write = 1'b0; d_addr = 32'h8000_5000;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk_cnt++; if (m_valid !== 1'b1 || m_addr !== 32'h0040_0010 || busy !== 1'b1 ||
                           i_addr_ok !== 1'b0 || d_addr_ok !== 1'b0)
                $display("FAIL bp_hold%0d: got v=%0h a=%0h busy=%0h iok=%0h dok=%0h expected 1 400010 1 0 0",
                         j, m_valid, m_addr, busy, i_addr_ok, d_addr_ok);
            else pass_cnt++;
            @(negedge clk);
        end
        d_valid = 1'b0;
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hbad0_bad0;
        #1;
        chk_cnt++; if (i_addr_ok !== 1'b1 || i_data_ok !== 1'b0 || i_data !== 32'h0)
            $display("FAIL bp_both_ok: got aok=%0h dok=%0h data=%0h expected 1 0 0", i_addr_ok, i_data_ok, i_data);
        else pass_cnt++;
        @(negedge clk);
        m_addr_ok = 1'b0; m_data_ok = 1'b0;
        #1;
        chk_cnt++; if (dbg_state !== 2'd2 || i_data_ok !== 1'b0 || i_data !== 32'h0)
            $display("FAIL bp_wait_idle: got st=%0d ok=%0h data=%0h expected 2 0 0", dbg_state, i_data_ok, i_data);
        else pass_cnt++;
        @(negedge clk);
        m_data_ok = 1'b1; m_rdata = 32'h8fa2_0004;
        #1;
        chk_cnt++; if (i_data_ok !== 1'b1 || i_data !== 32'h8fa2_0004 || d_data_ok !== 1'b0)
            $display("FAIL bp_data: got ok=%0h data=%0h dok=%0h expected 1 8fa20004 0", i_data_ok, i_data, d_data_ok);
        else pass_cnt++;
        @(negedge clk);
        m_data_ok = 1'b0; m_rdata = '0;
    endtask

    task automatic test_reset_mid_wait();
        i_valid = 1'b1; i_addr = 32'h0040_0020;
        d_valid = 1'b1; d_write = 1'b0; d_addr = 32'h8000_4000;
        @(negedge clk);
        m_addr_ok = 1'b1;
        #1;
        chk_cnt++; if (d_addr_ok !== 1'b1) $display("FAIL rst_pre_accept: got %0h expected 1", d_addr_ok); else pass_cnt++;
        d_valid = 1'b0; i_valid = 1'b0;
        @(negedge clk);
        m_addr_ok = 1'b0;
        #1;
        chk_cnt++; if (dbg_state !== 2'd2 || dbg_starve_cnt !== 3'd1)
            $display("FAIL rst_pre_wait: got st=%0d cnt=%0d expected 2 1", dbg_state, dbg_starve_cnt);
        else pass_cnt++;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        m_data_ok = 1'b1; m_rdata = 32'h5555_aaaa;
        #1;
        chk_cnt++; if (dbg_state !== 2'd0 || dbg_starve_cnt !== 3'd0)
            $display("FAIL rst_state: got st=%0d cnt=%0d expected 0 0", dbg_state, dbg_starve_cnt);
        else pass_cnt++;
        chk_cnt++; if ({m_valid, m_write, m_addr, m_strobe, m_wdata, i_addr_ok, i_data_ok, i_data,
                        d_addr_ok, d_data_ok, d_rdata, busy} !== '0)
            $display("FAIL rst_outputs: got d_data_ok=%0h d_rdata=%0h m_addr=%0h busy=%0h expected all 0",
                     d_data_ok, d_rdata, m_addr, busy);
        else pass_cnt++;
        @(negedge clk);
        m_data_ok = 1'b0; m_rdata = '0;
        #1;
        chk_cnt++; if (dbg_state !== 2'd0 || busy !== 1'b0)
            $display("FAIL rst_late_data: got st=%0d busy=%0h expected 0 0", dbg_state, busy);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_starvation();
        test_backpressure();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one memory bus port between the instruction fetch bus (I) and the data bus (D) of the MIPS pipeline.
- Allows one outstanding transaction at a time.
- D has priority over I. A starvation counter guarantees fetch progress.
- Sits between the fetch/memory stages and the memory/cache interface. It sequences each transaction as request → address accept → data return.

Parameters:
- STARVE_LIMIT, 4: number of consecutive D grants made while I is waiting, after which I is granted next regardless of D.
- CNT_W, 3: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- i_valid  in  1  fetch request pending
- i_addr  in  32  fetch address
- i_addr_ok  out  1  fetch request accepted
- i_data_ok  out  1  fetch data valid
- i_data  out  32  fetch data
- d_valid  in  1  data request pending
- d_addr  in  32  data address
- d_write  in  1  1 = store, 0 = load
- d_strobe  in  4  byte enables for a store
- d_wdata  in  32  store data
- d_addr_ok  out  1  data request accepted
- d_data_ok  out  1  load data valid / store completed
- d_rdata  out  32  load data
- m_valid  out  1  request to memory
- m_addr  out  32  memory address
- m_write  out  1  memory write
- m_strobe  out  4  memory byte enables
- m_wdata  out  32  memory write data
- m_addr_ok  in  1  memory accepted request
- m_data_ok  in  1  memory response valid
- m_rdata  in  32  memory read data
- busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- States: IDLE, ISSUE, WAIT. Register gnt_d (1 = D owns the bus).
- Reset (resetn = 0 at a clk edge):
  - state ← IDLE, gnt_d ← 0, starve_cnt ← 0, latched request fields ← 0.
  - All outputs read 0 in the following cycle: m_valid, m_write, m_addr, m_strobe, m_wdata, all *_ok, i_data, d_rdata, busy.
  - Reset mid-transaction abandons the transaction. No data_ok is produced for it. A late m_data_ok arriving in IDLE is ignored.
- IDLE:
  - If d_valid and starve_cnt != STARVE_LIMIT → grant D.
  - Else if i_valid → grant I.
  - Else if d_valid → grant D.
  - On a grant: latch the winner's addr, write, strobe and wdata (I: write = 0, strobe = 0, wdata = 0), set gnt_d, go to ISSUE.
- Starvation counter, updated on each grant:
  - D granted while i_valid = 1 → starve_cnt + 1, saturating at STARVE_LIMIT.
  - I granted → 0.
  - D granted while i_valid = 0 → unchanged.
- ISSUE:
  - m_valid = 1 and m_* driven from latched registers only. Memory-side outputs never depend combinationally on i_*/d_* inputs.
  - The winner's addr_ok = m_addr_ok, combinational, same cycle.
  - On m_addr_ok → WAIT.
- WAIT:
  - m_valid = 0.
  - Winner's data_ok = m_data_ok.
  - Winner's data output = m_rdata while m_data_ok = 1, else 0.
  - On m_data_ok → IDLE. The next grant is decided in the IDLE cycle that follows, so there is one bubble cycle between transactions.
- Loser outputs:
  - The non-granted requester's addr_ok, data_ok and data are always 0.
  - *_ok outputs are 0 in IDLE.
- Requester rule: a requester holds valid and all request fields stable until it sees its addr_ok. The arbiter does not depend on this, because it uses latched copies.
- Latency, uncontended, with memory accepting and returning after one cycle each:
  - request at cycle t (IDLE)
  - m_valid at t+1
  - addr_ok at t+1
  - data_ok at t+2
- Simultaneous i_valid and d_valid in IDLE → D wins unless starve_cnt == STARVE_LIMIT.
- m_addr_ok and m_data_ok both high in ISSUE: only m_addr_ok is acted on. Memory returns data no earlier than the cycle after acceptance.
- busy = 1 in ISSUE and WAIT.

Test Plan:
- Uncontended fetch:
  - Stimulus: i_valid = 1, i_addr = 0xbfc00000. Memory gives addr_ok at the first m_valid cycle and data_ok one cycle later with 0x24020001.
  - Required response: i_addr_ok at t+1, i_data_ok with i_data = 0x24020001 at t+2, d_* outputs stay 0.
- Store pass-through:
  - Stimulus: d_valid = 1, d_write = 1, d_addr = 0x80001000, d_strobe = 4'b0011, d_wdata = 0xdeadbeef.
  - Required response: m_write = 1, m_strobe = 0011, m_wdata = 0xdeadbeef while m_valid. Then d_data_ok pulses for 1 cycle.
- Contention:
  - Stimulus: i_valid and d_valid high together in IDLE, starve_cnt = 0.
  - Required response: D transaction first. I is granted in the IDLE cycle after D completes, if D has dropped.
- Starvation with STARVE_LIMIT = 4:
  - Stimulus: i_valid and d_valid held high continuously.
  - Required response: grant sequence D,D,D,D,I,D,D,D,D,I. starve_cnt returns to 0 after each I grant.
- Memory backpressure:
  - Stimulus: m_addr_ok held low for 5 cycles.
  - Required response: m_valid = 1 and m_addr stable all 5 cycles, no addr_ok to either requester, busy = 1.
- Reset mid-WAIT:
  - Stimulus: resetn = 0 for 1 cycle during WAIT, then m_data_ok arrives.
  - Required response: state IDLE, no data_ok to the requester, all outputs 0, starve_cnt = 0.
